// File: rtl/sync_timing_gen.sv
// rtl/sync_timing_gen.sv - raster sync timing generator (HS, VS, DE, pixel coordinates)
// Counters walk active -> front porch -> sync -> back porch; outputs are registered decodes of them.
module sync_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic        PCLK,
   input  logic        RST_N,
   input  logic        EN,
   output logic        HS,
   output logic        VS,
   output logic        DE,
   output logic [11:0] X,
   output logic [11:0] Y,
   output logic        FRAME_START
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_too_large
      $error("sync_timing_gen: line or frame total exceeds 12-bit counter range");
   end

   // 13-bit window bounds so a sync window ending exactly at 4096 still compares correctly
   localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
   localparam logic [12:0] HS_BEGIN   = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] HS_END     = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
   localparam logic [12:0] VS_BEGIN   = 13'(V_ACTIVE + V_FP);
   localparam logic [12:0] VS_END     = 13'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

   logic [11:0] h_q, h_d;
   logic [11:0] v_q, v_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        de_q, de_d;
   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic        fs_q, fs_d;

   logic        h_in_active;
   logic        v_in_active;
   logic        h_in_sync;
   logic        v_in_sync;
   logic        h_wrap;

   always_comb begin
      h_in_active = ({1'b0, h_q} < H_ACT_END);
      v_in_active = ({1'b0, v_q} < V_ACT_END);
      h_in_sync   = ({1'b0, h_q} >= HS_BEGIN) && ({1'b0, h_q} < HS_END);
      v_in_sync   = ({1'b0, v_q} >= VS_BEGIN) && ({1'b0, v_q} < VS_END);
      h_wrap      = (h_q == H_LAST);
   end

   // Everything holds while EN is low, so resuming continues on the very next pixel
   always_comb begin
      h_d  = h_q;
      v_d  = v_q;
      hs_d = hs_q;
      vs_d = vs_q;
      de_d = de_q;
      x_d  = x_q;
      y_d  = y_q;
      fs_d = fs_q;
      if (EN) begin
         h_d = h_wrap ? 12'd0 : h_q + 12'd1;
         if (h_wrap) begin
            v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
         end
         hs_d = h_in_sync ? HS_POL : ~HS_POL;
         vs_d = v_in_sync ? VS_POL : ~VS_POL;
         de_d = h_in_active && v_in_active;
         x_d  = (h_in_active && v_in_active) ? h_q : 12'd0;
         y_d  = (h_in_active && v_in_active) ? v_q : 12'd0;
         fs_d = (h_q == 12'd0) && (v_q == 12'd0);
      end
   end

   always_ff @(posedge PCLK or negedge RST_N) begin
      if (!RST_N) begin
         h_q  <= 12'd0;
         v_q  <= 12'd0;
         hs_q <= ~HS_POL;
         vs_q <= ~VS_POL;
         de_q <= 1'b0;
         x_q  <= 12'd0;
         y_q  <= 12'd0;
         fs_q <= 1'b0;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         de_q <= de_d;
         x_q  <= x_d;
         y_q  <= y_d;
         fs_q <= fs_d;
      end
   end

   assign HS          = hs_q;
   assign VS          = vs_q;
   assign DE          = de_q;
   assign X           = x_q;
   assign Y           = y_q;
   assign FRAME_START = fs_q;

endmodule

// File: tb/tb_sync_timing_gen.sv
// tb/tb_sync_timing_gen.sv - scoreboard bench for sync_timing_gen on a reduced 15x8 raster
module tb_sync_timing_gen;

   // Raster: H = 8 active, 2 fp, 3 sync (h 10..12), 2 bp; V = 4 active, 1 fp, 2 sync (v 5..6), 1 bp
   localparam int HT = 15;
   localparam int VT = 8;
   localparam int FT = HT * VT;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        hs0, vs0, de0, fs0;
   logic [11:0] x0, y0;
   logic        hs1, vs1, de1, fs1;
   logic [11:0] x1, y1;

   sync_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut0 (
      .PCLK(pclk), .RST_N(rst_n), .EN(en),
      .HS(hs0), .VS(vs0), .DE(de0), .X(x0), .Y(y0), .FRAME_START(fs0)
   );

   sync_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut1 (
      .PCLK(pclk), .RST_N(rst_n), .EN(en),
      .HS(hs1), .VS(vs1), .DE(de1), .X(x1), .Y(y1), .FRAME_START(fs1)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      bit hs_act;
      bit vs_act;
      bit de;
      int x;
      int y;
      bit fs;
      int h;
      int v;
   } exp_t;

   exp_t sb_q[$];
   exp_t last;
   int   p;
   int   checks = 0;
   int   errors = 0;
   int   de_cnt = 0, fs_cnt = 0, hs_cnt = 0, vs_cnt = 0;

   function automatic exp_t model(input int pos);
      exp_t e;
      e.h      = pos % HT;
      e.v      = pos / HT;
      e.de     = (e.h < 8) && (e.v < 4);
      e.hs_act = (e.h >= 10) && (e.h <= 12);
      e.vs_act = (e.v == 5) || (e.v == 6);
      e.x      = e.de ? e.h : 0;
      e.y      = e.de ? e.v : 0;
      e.fs     = (pos == 0);
      return e;
   endfunction

   function automatic exp_t reset_exp();
      exp_t e;
      e.hs_act = 1'b0;
      e.vs_act = 1'b0;
      e.de     = 1'b0;
      e.x      = 0;
      e.y      = 0;
      e.fs     = 1'b0;
      e.h      = -1;
      e.v      = -1;
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic step(input bit e);
      @(negedge pclk);
      en = e;
      if (e) begin
         last = model(p);
         p = (p + 1) % FT;
      end
      sb_q.push_back(last);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_hs0"}, int'(hs0), 1);
      chk({tag, "_vs0"}, int'(vs0), 1);
      chk({tag, "_hs1"}, int'(hs1), 0);
      chk({tag, "_vs1"}, int'(vs1), 0);
      chk({tag, "_de0"}, int'(de0), 0);
      chk({tag, "_x0"},  int'(x0),  0);
      chk({tag, "_y0"},  int'(y0),  0);
      chk({tag, "_fs0"}, int'(fs0), 0);
   endtask

   always begin : monitor
      exp_t e;
      @(posedge pclk);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("hs0", int'(hs0), e.hs_act ? 0 : 1);
         chk("vs0", int'(vs0), e.vs_act ? 0 : 1);
         chk("de0", int'(de0), int'(e.de));
         chk("x0",  int'(x0),  e.x);
         chk("y0",  int'(y0),  e.y);
         chk("fs0", int'(fs0), int'(e.fs));
         chk("hs1", int'(hs1), int'(e.hs_act));
         chk("vs1", int'(vs1), int'(e.vs_act));
         chk("de1", int'(de1), int'(e.de));
         chk("x1",  int'(x1),  e.x);
         chk("y1",  int'(y1),  e.y);
         chk("fs1", int'(fs1), int'(e.fs));
         if (de0) de_cnt++;
         if (fs0) fs_cnt++;
         if (!hs0) hs_cnt++;
         if (!vs0) vs_cnt++;
      end
   end

   initial begin
      int n;
      p    = 0;
      last = reset_exp();

      repeat (3) @(negedge pclk);
      check_reset_outputs("rst");

      rst_n = 1'b1;
      sb_q.push_back(last);

      // Two full frames from (0,0)
      repeat (2 * FT) step(1'b1);
      @(posedge pclk);
      #2;
      chk("de_cycles_2frames", de_cnt, 64);
      chk("fs_pulses_2frames", fs_cnt, 2);
      chk("hs_cycles_2frames", hs_cnt, 48);
      chk("vs_cycles_2frames", vs_cnt, 60);

      // Freeze for 37 cycles while X=5 is on the outputs
      n = 0;
      while (!(last.de && last.x == 5) && n < 200) begin
         step(1'b1);
         n++;
      end
      chk("wait_x5_in_budget", (n < 200) ? 1 : 0, 1);
      repeat (37) step(1'b0);
      repeat (150) step(1'b1);

      // Asynchronous reset while HS is active on line 2
      n = 0;
      while (!(last.hs_act && last.v == 2 && last.h == 11) && n < 400) begin
         step(1'b1);
         n++;
      end
      chk("wait_hs_line2_in_budget", (n < 400) ? 1 : 0, 1);
      @(posedge pclk);
      #3;
      chk("hs0_before_async_rst", int'(hs0), 0);
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      chk("hs0_async_rst", int'(hs0), 1);
      chk("hs1_async_rst", int'(hs1), 0);
      chk("de0_async_rst", int'(de0), 0);
      p    = 0;
      last = reset_exp();
      repeat (2) @(negedge pclk);
      check_reset_outputs("rst2");
      rst_n = 1'b1;
      sb_q.push_back(last);
      repeat (FT + 20) step(1'b1);

      @(posedge pclk);
      #2;
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
